mms_stream_nnum: RTL

//   Streaming max/min selector over a frame of NUM samples, WIDTH bits each.

---
 rtl/mms_stream_nnum.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mms_stream_nnum.sv
// mms_stream_nnum: streaming max/min selector over frames of NUM unsigned samples.
//
// One sample is accepted per in_valid cycle. There is no backpressure. The mode is
// captured from select on the first sample of each frame and held for the rest of
// that frame. When the NUM-th sample is accepted, the selected value is registered
// into result, and out_valid pulses for one cycle.
//
// Optional feature: define MMS_INDEX_EN to add result_idx. This output is the
// frame-relative position of the winning sample.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   clear      synchronous abort of the current frame; a sample in the same cycle is dropped
//   in_valid   in_data is valid this cycle
//   select     0 = max, 1 = min; sampled on the first sample of a frame only
//   in_data    sample, WIDTH bits unsigned
//   result     selected value of the last completed frame
//   out_valid  one-cycle pulse when result updates
//   busy       a frame is in progress
//   result_idx winner position 0..NUM-1 (MMS_INDEX_EN only)

module mms_stream_nnum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NUM   = 4,
  localparam int unsigned CW   = $clog2(NUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             select,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             busy
`ifdef MMS_INDEX_EN
  ,
  output logic [CW-1:0]    result_idx
`endif
);

  localparam logic [CW-1:0] LastCnt = CW'(NUM - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic             take;
  logic [WIDTH-1:0] final_val;

  // best is the earlier operand. Ties keep best for max and take the new sample for min.
  assign take      = (best_q < in_data) ^ sel_q;
  assign final_val = take ? in_data : best_q;

`ifdef MMS_INDEX_EN
  logic [CW-1:0] best_idx_q, best_idx_d;
  logic [CW-1:0] result_idx_q, result_idx_d;
  logic [CW-1:0] final_idx;

  // In StAcc, cnt_q equals the frame position of the sample being accepted.
  assign final_idx = take ? cnt_q : best_idx_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    best_d   = best_q;
    sel_d    = sel_q;
    result_d = result_q;
    valid_d  = 1'b0;
`ifdef MMS_INDEX_EN
    best_idx_d   = best_idx_q;
    result_idx_d = result_idx_q;
`endif
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          best_d  = in_data;
          sel_d   = select;
          cnt_d   = CW'(1);
          state_d = StAcc;
`ifdef MMS_INDEX_EN
          best_idx_d = '0;
`endif
        end
        StAcc: begin
          best_d = final_val;
`ifdef MMS_INDEX_EN
          best_idx_d = final_idx;
`endif
          if (cnt_q == LastCnt) begin
            // The frame result uses the current sample, not the registered best.
            result_d = final_val;
            valid_d  = 1'b1;
            cnt_d    = '0;
            state_d  = StIdle;
`ifdef MMS_INDEX_EN
            result_idx_d = final_idx;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      best_q   <= '0;
      sel_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      best_q   <= best_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef MMS_INDEX_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_idx_q   <= '0;
      result_idx_q <= '0;
    end else begin
      best_idx_q   <= best_idx_d;
      result_idx_q <= result_idx_d;
    end
  end

  assign result_idx = result_idx_q;
`endif

  assign result    = result_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StAcc);

endmodule
